// File: rtl/fft_gen_pkg.sv
// Shared types and constants for the synthetic FFT frame source (fft_frame_gen).
package fft_gen_pkg;
    localparam int BIN_W            = 16;
    localparam int AMP_W_MAX        = 31;
    localparam int DEFAULT_BIN_STEP = 200;

    // Fibonacci taps for x^16+x^14+x^13+x^11+1 (state bits 15,13,12,10)
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        QUAD_POS_RE = 2'd0,
        QUAD_POS_IM = 2'd1,
        QUAD_NEG_RE = 2'd2,
        QUAD_NEG_IM = 2'd3
    } quad_t;

    typedef struct packed {
        logic [BIN_W-1:0]     bin;
        logic [AMP_W_MAX-1:0] amp;
        quad_t                quad;
    } peak_cfg_t;

    function automatic logic [BIN_W-1:0] default_bin(input int slot);
        return BIN_W'(DEFAULT_BIN_STEP * (slot + 1));
    endfunction
endpackage

// File: rtl/fft_frame_gen_lfsr16.sv
// 16-bit Fibonacci LFSR feeding the noisy floor of fft_frame_gen.
// Only elaborated when FFT_GEN_NOISE_EN is defined.
`ifdef FFT_GEN_NOISE_EN
module lfsr16
    import fft_gen_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [15:0] state
);
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LFSR_SEED;
        end else if (enable) begin
            state <= {state[14:0], ^(state & LFSR_TAPS)};
        end
    end
endmodule
`endif

// File: rtl/fft_frame_gen.sv
// Synthetic FFT frame source: BATCH_SIZE bins per frame with NPEAKS peak slots over a floor.
// Define FFT_GEN_NOISE_EN to add LFSR noise to floor bins.
module fft_frame_gen
    import fft_gen_pkg::*;
#(
    parameter int BATCH_SIZE = 1024,
    parameter int DATA_WIDTH = 16,
    parameter int NPEAKS     = 4,
    parameter int GAP_CYCLES = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         continuous,
    input  logic                         cfg_we,
    input  logic [$clog2(NPEAKS)-1:0]    cfg_idx,
    input  logic [15:0]                  cfg_bin,
    input  logic [DATA_WIDTH-2:0]        cfg_amp,
    input  logic [1:0]                   cfg_quad,
    input  logic [DATA_WIDTH-2:0]        cfg_floor,
    output logic                         source_sop,
    output logic                         source_eop,
    output logic                         source_valid,
    output logic signed [DATA_WIDTH-1:0] source_re,
    output logic signed [DATA_WIDTH-1:0] source_im,
    output logic                         busy,
    output logic [15:0]                  frame_count
);
    localparam int IDX_W = $clog2(NPEAKS);
    localparam int CNT_W = $clog2(BATCH_SIZE);
    localparam int GAP_W = $clog2(GAP_CYCLES + 1);
    localparam logic [CNT_W-1:0] LAST_BIN  = CNT_W'(BATCH_SIZE - 1);
    localparam logic [GAP_W-1:0] LAST_GAP  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [BIN_W:0]   BIN_LIMIT = (BIN_W + 1)'(BATCH_SIZE);

    typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

    state_t                       state;
    logic [CNT_W-1:0]             bin_cnt;
    logic [GAP_W-1:0]             gap_cnt;
    peak_cfg_t                    stage  [NPEAKS];
    peak_cfg_t                    active [NPEAKS];
    peak_cfg_t                    sel    [NPEAKS];
    logic [DATA_WIDTH-2:0]        stage_floor, active_floor, sel_floor;

    logic                         load;
    logic [CNT_W-1:0]             nxt_bin;
    logic [BIN_W:0]               key, slot_v;
    logic                         hit_c, hit_s;
    logic [DATA_WIDTH-2:0]        amp_c, amp_s, pk_amp;
    quad_t                        quad_c, quad_s, pk_quad;
    logic signed [DATA_WIDTH-1:0] mag, floor_re, floor_im, nxt_re, nxt_im;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NPEAKS; i++) begin
                stage[i] <= '{bin: default_bin(i), amp: '0, quad: QUAD_POS_RE};
            end
            stage_floor <= '0;
        end else begin
            stage_floor <= cfg_floor;
            if (cfg_we) begin
                stage[cfg_idx] <= '{bin: cfg_bin, amp: AMP_W_MAX'(cfg_amp), quad: quad_t'(cfg_quad)};
            end
        end
    end

    // On a frame-start edge the first bin is built from staging, since active is only loaded on that edge
    always_comb begin
        load    = (state == IDLE && start) ||
                  (state == GAP && gap_cnt == LAST_GAP && continuous);
        nxt_bin = load ? '0 : bin_cnt + 1'b1;
        for (int i = 0; i < NPEAKS; i++) begin
            sel[i] = load ? stage[i] : active[i];
        end
        sel_floor = load ? stage_floor : active_floor;
    end

    // Descending scan so the lowest-index matching slot wins
    always_comb begin
        key    = (BIN_W + 1)'(nxt_bin);
        slot_v = '0;
        hit_c  = 1'b0;
        hit_s  = 1'b0;
        amp_c  = '0;
        amp_s  = '0;
        quad_c = QUAD_POS_RE;
        quad_s = QUAD_POS_RE;
        for (int i = NPEAKS - 1; i >= 0; i--) begin
            slot_v = {1'b0, sel[i].bin};
            if (sel[i].amp != '0) begin
                if (slot_v == key) begin
                    hit_c  = 1'b1;
                    amp_c  = sel[i].amp[DATA_WIDTH-2:0];
                    quad_c = sel[i].quad;
                end
                if (slot_v < BIN_LIMIT && (slot_v == key + 1'b1 || slot_v + 1'b1 == key)) begin
                    hit_s  = 1'b1;
                    amp_s  = sel[i].amp[DATA_WIDTH-2:0];
                    quad_s = sel[i].quad;
                end
            end
        end
        pk_amp  = hit_c ? amp_c : (amp_s >> 1);
        pk_quad = hit_c ? quad_c : quad_s;
    end

`ifdef FFT_GEN_NOISE_EN
    logic [15:0] lfsr_state;
    logic        unused_lfsr_hi;

    lfsr16 u_lfsr (
        .clk    (clk),
        .reset  (reset),
        .enable (source_valid),
        .state  (lfsr_state)
    );

    assign unused_lfsr_hi = ^lfsr_state[15:8];

    function automatic logic signed [DATA_WIDTH-1:0] sat_dw(input logic signed [DATA_WIDTH:0] x);
        if (x > $signed({2'b00, {(DATA_WIDTH-1){1'b1}}})) begin
            return {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end else if (x < $signed({2'b11, {(DATA_WIDTH-1){1'b0}}})) begin
            return {1'b1, {(DATA_WIDTH-1){1'b0}}};
        end
        return x[DATA_WIDTH-1:0];
    endfunction

    always_comb begin
        floor_re = sat_dw($signed({2'b00, sel_floor}) +
                          $signed((DATA_WIDTH + 1)'(lfsr_state[3:0])) -
                          $signed((DATA_WIDTH + 1)'(8)));
        floor_im = DATA_WIDTH'($signed({1'b0, lfsr_state[7:4]}) - 5'sd8);
    end
`else
    assign floor_re = $signed({1'b0, sel_floor});
    assign floor_im = '0;
`endif

    always_comb begin
        mag    = $signed({1'b0, pk_amp});
        nxt_re = floor_re;
        nxt_im = floor_im;
        if (hit_c || hit_s) begin
            nxt_re = '0;
            nxt_im = '0;
            case (pk_quad)
                QUAD_POS_RE: nxt_re = mag;
                QUAD_POS_IM: nxt_im = mag;
                QUAD_NEG_RE: nxt_re = -mag;
                default:     nxt_im = -mag;
            endcase
        end
    end

    // Output register stage
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            bin_cnt      <= '0;
            gap_cnt      <= '0;
            source_sop   <= 1'b0;
            source_eop   <= 1'b0;
            source_valid <= 1'b0;
            source_re    <= '0;
            source_im    <= '0;
            busy         <= 1'b0;
            frame_count  <= '0;
        end else begin
            source_sop <= 1'b0;
            source_eop <= 1'b0;
            if (load) begin
                state        <= FRAME;
                bin_cnt      <= '0;
                busy         <= 1'b1;
                source_sop   <= 1'b1;
                source_valid <= 1'b1;
                source_re    <= nxt_re;
                source_im    <= nxt_im;
                active       <= stage;
                active_floor <= stage_floor;
            end else begin
                case (state)
                    FRAME: begin
                        if (bin_cnt == LAST_BIN) begin
                            state        <= GAP;
                            gap_cnt      <= '0;
                            source_valid <= 1'b0;
                            frame_count  <= frame_count + 16'd1;
                        end else begin
                            bin_cnt    <= nxt_bin;
                            source_eop <= (nxt_bin == LAST_BIN);
                            source_re  <= nxt_re;
                            source_im  <= nxt_im;
                        end
                    end
                    GAP: begin
                        if (gap_cnt == LAST_GAP) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            gap_cnt <= gap_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: doc/fft_frame_gen.md
# fft_frame_gen

Synthetic FFT frame source driving the spectrum-sink streaming interface (sop/eop/valid, re/im) consumed by the peak-detection stage. Emits frames of BATCH_SIZE complex bins containing up to NPEAKS configurable peaks, each with two shoulder bins and a selectable phase quadrant, over a flat or noisy floor. Used as bench stimulus and on-chip self-test source in place of the FFT core.

## Interface
- BATCH_SIZE, 1024, bins per frame (power of two, ≥ 8)
- DATA_WIDTH, 16, bits per re/im entry (two's complement)
- NPEAKS, 4, number of peak slots
- GAP_CYCLES, 8, idle cycles after each frame (≥ NPEAKS+2)

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- start  in  1  begin a frame (sampled in IDLE only)
- continuous  in  1  high: loop frames; sampled at end of each GAP
- cfg_we  in  1  write one peak slot into staging
- cfg_idx  in  $clog2(NPEAKS)  slot index
- cfg_bin  in  16  peak centre bin
- cfg_amp  in  DATA_WIDTH-1  peak amplitude, unsigned
- cfg_quad  in  2  phase quadrant: 0 (+a,0), 1 (0,+a), 2 (−a,0), 3 (0,−a)
- cfg_floor  in  DATA_WIDTH-1  floor amplitude, unsigned, staged like slots
- source_sop  out  1  first bin of frame
- source_eop  out  1  last bin of frame
- source_valid  out  1  entry valid
- source_re  out  DATA_WIDTH  real part
- source_im  out  DATA_WIDTH  imaginary part
- busy  out  1  high in FRAME or GAP
- frame_count  out  16  completed frames, wraps

## Operation
- States: IDLE, FRAME, GAP. IDLE→FRAME on start; FRAME→GAP after bin BATCH_SIZE−1; GAP→FRAME after GAP_CYCLES if continuous, else →IDLE. start ignored outside IDLE.
- Staging: cfg_we writes slot cfg_idx (bin, amp, quad); cfg_floor always staged. On IDLE→FRAME and GAP→FRAME edges, staging copies into active set; a write on that same edge goes to staging only (next frame).
- Bin k value, priority: lowest-index slot with bin==k gives full amplitude a; else lowest-index slot with bin==k±1 gives a>>>1; else floor. Amplitude a is placed per quad; negation never overflows since a < 2^(DATA_WIDTH−1).
- Slots with amp==0 are disabled. Bins outside 0..BATCH_SIZE−1 never match; shoulders at −1 or BATCH_SIZE are dropped (no wrap).
- Floor without macro: re=cfg_floor, im=0.
- frame_count increments on each eop cycle.

## Timing
- Reset values: source_sop/eop/valid=0, source_re/im=0, busy=0, frame_count=0, state IDLE, staging bins 200·(i+1), amps 0, quads 0, floor 0.
- Outputs registered. Edge sampling start=1 in IDLE presents bin 0 with sop=valid=1; one bin per cycle thereafter; eop with bin BATCH_SIZE−1; valid continuous through a frame.
- GAP: valid=sop=eop=0 for exactly GAP_CYCLES cycles; next frame's sop on the following cycle if continuous.
- re/im hold last value when valid=0 (don't-care for sinks).
- Reset mid-frame: all outputs return to reset values on that edge, no eop emitted, frame_count not incremented.

## Configuration
- FFT_GEN_NOISE_EN defined: 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances every valid cycle; floor re = cfg_floor + signed(lfsr[3:0]) − 8 and im = signed(lfsr[7:4]) − 8, saturated to DATA_WIDTH. Peak and shoulder bins get no noise.
- Not defined: no LFSR logic; floor is deterministic as above.

## Structure
- Package fft_gen_pkg: peak_cfg_t struct {bin, amp, quad}, quadrant enum, default bin constants, LFSR polynomial and seed.
- Sub-module lfsr16 (enable, reset, state out), instantiated only under FFT_GEN_NOISE_EN.

## Test plan
- Reset, slot 0 = (bin 200, amp 1000, quad 0), start pulse → sop at bin 0, bin 199 = (500,0), 200 = (1000,0), 201 = (500,0), eop at bin 1023, frame_count=1.
- quad 1/2/3 on slot 2 (bin 600, amp 64) → bin 600 = (0,64), (−64,0), (0,−64); shoulders (0,32), (−32,0), (0,−32).
- Slots 0,1 at bins 10 and 11, amps 100/200 → bin 10 = 100 (centre beats shoulder), bin 11 = 200, bin 9 = 50, bin 12 = 100.
- continuous=1 for 3 frames → exactly 8 invalid cycles between eop and next sop; cfg_amp change mid-frame appears only in the next frame; drop continuous → IDLE after the third GAP.
- Slot at bin 0 and bin 1023 → no wrapped shoulders; reset asserted at bin 500 → valid=0 next cycle, no eop, frame_count unchanged.
- With FFT_GEN_NOISE_EN, floor 100 → floor re in 92..107, im in −8..7; sequence identical after reset.
